// File: rtl/div.sv
// Sequential signed restoring divider (quotient/remainder truncated toward zero) with start/fin handshake.
// Latency: fin rises WD+2 edges after start is taken, or 2 edges for a zero divisor.
// Backpressure: holding start_div high keeps the result in DONE; there is no auto-restart.
module div #(
    parameter int WD = 6,
    parameter int WS = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_div,
    input  logic [WD-1:0] Dividend_div,
    input  logic [WS-1:0] Divisor_div,
    output logic [WD-1:0] Quot_div,
    output logic [WS-1:0] Rem_div,
    output logic          dz,
    output logic          ovf,
    output logic          fin
);

    localparam int CW = (WD > 2) ? $clog2(WD) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, ITER, SIGN, DONE} state_t;

    state_t        state;
    logic [WD-1:0] dvd_r;
    logic [WS-1:0] dvs_r;
    logic [WD-1:0] a;
    logic [WS:0]   p;
    logic [WS-1:0] dmag;
    logic [CW-1:0] cnt;
    logic          sign_q;
    logic          sign_r;

    logic [WS:0]   p_sh;
    logic [WS+1:0] trial;
    logic          dvd_neg;
    logic          dvs_neg;
    logic [WD-1:0] dvd_mag;
    logic [WS-1:0] dvs_mag;
    logic          ovf_case;

    always_comb begin
        p_sh     = {p[WS-1:0], a[WD-1]};
        trial    = {1'b0, p_sh} - {2'b00, dmag};
        dvd_neg  = dvd_r[WD-1];
        dvs_neg  = dvs_r[WS-1];
        // The most negative dividend negates to 100..0, which is its correct unsigned magnitude.
        dvd_mag  = dvd_neg ? -dvd_r : dvd_r;
        dvs_mag  = dvs_neg ? -dvs_r : dvs_r;
        ovf_case = (dvd_r == {1'b1, {(WD-1){1'b0}}}) && (dvs_r == '1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dvd_r    <= '0;
            dvs_r    <= '0;
            a        <= '0;
            p        <= '0;
            dmag     <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            Quot_div <= '0;
            Rem_div  <= '0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
            fin      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_div) begin
                        dvd_r <= Dividend_div;
                        dvs_r <= Divisor_div;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    ovf    <= 1'b0;
                    dz     <= (dvs_r == '0);
                    sign_q <= dvd_neg ^ dvs_neg;
                    sign_r <= dvd_neg;
                    a      <= dvd_mag;
                    dmag   <= dvs_mag;
                    p      <= '0;
                    cnt    <= CW'(WD - 1);
                    // Zero divisor skips the iterations but still passes SIGN to publish zeros.
                    state  <= (dvs_r == '0) ? SIGN : ITER;
                end
                ITER: begin
                    if (!trial[WS+1]) begin
                        p <= trial[WS:0];
                        a <= {a[WD-2:0], 1'b1};
                    end else begin
                        p <= p_sh;
                        a <= {a[WD-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    if (dz) begin
                        Quot_div <= '0;
                        Rem_div  <= '0;
                        ovf      <= 1'b0;
                    end else begin
                        Quot_div <= sign_q ? -a : a;
                        Rem_div  <= sign_r ? -p[WS-1:0] : p[WS-1:0];
                        ovf      <= ovf_case;
                    end
                    fin   <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    if (!start_div) begin
                        fin   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div at WD=6, WS=3: expectations come from an integer truncating-division model.
module tb_div;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_div;
    logic [5:0] Dividend_div;
    logic [2:0] Divisor_div;
    logic [5:0] Quot_div;
    logic [2:0] Rem_div;
    logic       dz;
    logic       ovf;
    logic       fin;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [5:0] q;
        logic [2:0] r;
        logic       dz;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    div #(.WD(6), .WS(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_div   (start_div),
        .Dividend_div(Dividend_div),
        .Divisor_div (Divisor_div),
        .Quot_div    (Quot_div),
        .Rem_div     (Rem_div),
        .dz          (dz),
        .ovf         (ovf),
        .fin         (fin)
    );

    function automatic void push_exp(input logic [5:0] a, input logic [2:0] b);
        exp_t e;
        int ai, bi, qi, ri;
        ai = $signed(a);
        bi = $signed(b);
        if (bi == 0) begin
            e.q = '0; e.r = '0; e.dz = 1'b1; e.ovf = 1'b0; e.lat = 2;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            e.q = qi[5:0]; e.r = ri[2:0]; e.dz = 1'b0;
            e.ovf = (ai == -32 && bi == -1);
            e.lat = 8;
        end
        sb.push_back(e);
    endfunction

    // Edge 0 is the edge that takes the request; lat is the edge after which fin is seen, -1 on timeout.
    task automatic launch(input logic [5:0] a, input logic [2:0] b, input bit hold, output int lat);
        start_div    = 1'b1;
        Dividend_div = a;
        Divisor_div  = b;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start_div = 1'b0;
        Dividend_div = 6'($urandom);
        Divisor_div  = 3'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (fin === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_op;
        start_div = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0; start_div = 1'b0; Dividend_div = '0; Divisor_div = '0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({Quot_div, Rem_div, dz, ovf, fin} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got q=%b r=%b dz=%b ovf=%b fin=%b, expected all 0", Quot_div, Rem_div, dz, ovf, fin);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (fin !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: got fin=%b, expected 0", fin);
        end
    endtask

    // Pulse-start ops; after each, fin must drop and the result must hold in IDLE.
    task automatic run_table(input string name, input logic [5:0] ta[], input logic [2:0] tb[]);
        exp_t e;
        int lat;
        for (int i = 0; i < ta.size(); i++) begin
            push_exp(ta[i], tb[i]);
            launch(ta[i], tb[i], 1'b0, lat);
            e = sb.pop_front();
            n_chk++;
            if (lat !== e.lat) begin
                n_fail++;
                $display("FAIL %s_latency %0d/%0d: got %0d, expected %0d", name, $signed(ta[i]), $signed(tb[i]), lat, e.lat);
            end
            n_chk++;
            if ({Quot_div, Rem_div, dz, ovf} !== {e.q, e.r, e.dz, e.ovf}) begin
                n_fail++;
                $display("FAIL %s_result %0d/%0d: got q=%b r=%b dz=%b ovf=%b, expected q=%b r=%b dz=%b ovf=%b",
                         name, $signed(ta[i]), $signed(tb[i]), Quot_div, Rem_div, dz, ovf, e.q, e.r, e.dz, e.ovf);
            end
            release_op();
            n_chk++;
            if ({fin, Quot_div, Rem_div, dz, ovf} !== {1'b0, e.q, e.r, e.dz, e.ovf}) begin
                n_fail++;
                $display("FAIL %s_hold %0d/%0d: got fin=%b q=%b r=%b dz=%b ovf=%b, expected fin=0 q=%b r=%b dz=%b ovf=%b",
                         name, $signed(ta[i]), $signed(tb[i]), fin, Quot_div, Rem_div, dz, ovf, e.q, e.r, e.dz, e.ovf);
            end
        end
    endtask

    task automatic test_signed;
        // 13/3, -13/3, 13/-4
        logic [5:0] ta[] = '{6'd13, 6'd51, 6'd13};
        logic [2:0] tb[] = '{3'd3, 3'd3, 3'b100};
        run_table("signed", ta, tb);
    endtask

    task automatic test_ovf;
        // -32/-1 overflows; -32/1 must clear ovf at its LOAD
        logic [5:0] ta[] = '{6'b100000, 6'b100000};
        logic [2:0] tb[] = '{3'b111, 3'd1};
        run_table("ovf", ta, tb);
    endtask

    task automatic test_dz;
        logic [5:0] ta[] = '{6'd21, 6'd6};
        logic [2:0] tb[] = '{3'd0, 3'd2};
        run_table("dz", ta, tb);
    endtask

    task automatic test_abort;
        exp_t e;
        int lat;
        start_div = 1'b1; Dividend_div = 6'd31; Divisor_div = 3'd2;
        @(posedge clk);
        @(negedge clk);
        start_div = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_chk++;
        if ({Quot_div, Rem_div, dz, ovf, fin} !== 12'h000) begin
            n_fail++;
            $display("FAIL abort_clear: got q=%b r=%b dz=%b ovf=%b fin=%b, expected all 0", Quot_div, Rem_div, dz, ovf, fin);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        n_chk++;
        if (fin !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_finish: got fin=%b, expected 0", fin);
        end
        push_exp(6'd31, 3'd2);
        launch(6'd31, 3'd2, 1'b0, lat);
        e = sb.pop_front();
        n_chk++;
        if (lat !== e.lat) begin
            n_fail++;
            $display("FAIL abort_rerun_latency: got %0d, expected %0d", lat, e.lat);
        end
        n_chk++;
        if ({Quot_div, Rem_div, dz, ovf} !== {e.q, e.r, e.dz, e.ovf}) begin
            n_fail++;
            $display("FAIL abort_rerun_result: got q=%b r=%b, expected q=%b r=%b", Quot_div, Rem_div, e.q, e.r);
        end
        release_op();
    endtask

    task automatic test_sweep_hold;
        exp_t e;
        int lat;
        for (int a = 0; a < 64; a++) begin
            for (int b = 1; b < 8; b++) begin
                push_exp(6'(a), 3'(b));
                launch(6'(a), 3'(b), 1'b1, lat);
                e = sb.pop_front();
                n_chk++;
                if (lat !== e.lat || {Quot_div, Rem_div, dz, ovf} !== {e.q, e.r, e.dz, e.ovf}) begin
                    n_fail++;
                    $display("FAIL sweep %0d/%0d: got lat=%0d q=%b r=%b dz=%b ovf=%b, expected lat=%0d q=%b r=%b dz=%b ovf=%b",
                             $signed(6'(a)), $signed(3'(b)), lat, Quot_div, Rem_div, dz, ovf, e.lat, e.q, e.r, e.dz, e.ovf);
                end
                repeat (3) @(negedge clk);
                n_chk++;
                if ({fin, Quot_div, Rem_div} !== {1'b1, e.q, e.r}) begin
                    n_fail++;
                    $display("FAIL sweep_held %0d/%0d: got fin=%b q=%b r=%b, expected fin=1 q=%b r=%b",
                             $signed(6'(a)), $signed(3'(b)), fin, Quot_div, Rem_div, e.q, e.r);
                end
                release_op();
                n_chk++;
                if (fin !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep_release %0d/%0d: got fin=%b, expected 0", $signed(6'(a)), $signed(3'(b)), fin);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_signed();
        test_ovf();
        test_dz();
        test_abort();
        test_sweep_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
